// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, clock frequency and default frame shape.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLK_FREQ          = 50_000_000;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_STOP_BITS = 1;
  localparam int CNT_W             = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector; rise is one clk cycle wide
// per rising edge of async_in. Shared between the transmitter and a future receiver.
module uart_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter paced by an external baud square wave; one frame per accepted word.
// Define UART_TX_PARITY_EN to add a parity bit (sense chosen by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int STOP_BITS  = DEFAULT_STOP_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  logic bit_tick;

  uart_edge_det u_baud_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (baud_clk),
    .rise     (bit_tick)
  );

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 parity_q, parity_d;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Handshake: a word is taken on any clk edge where tx_valid and tx_ready are both 1;
  // tx_ready is high only in IDLE, so inputs are ignored for the whole frame.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    parity_d = parity_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          state_d = SYNC;
          shift_d = tx_data;
          cnt_d   = '0;
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ ODD_BIT;
`else
          parity_d = 1'b0;
`endif
        end
      end
      // SYNC aligns the frame to the next tick so the start bit is a full bit period.
      SYNC:  if (bit_tick) state_d = START;
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            stop_d = 1'b0;
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (stop_q == LAST_STOP) state_d = IDLE;
          else stop_d = ~stop_q;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule
